sum_accumulator: RTL and testbench

- Downstream consumer of the 4-bit adder stage's 5-bit sum.
- Accepts a stream of sums over a valid/ready handshake and accumulates exactly CNT samples per block.
- Presents the block total and block average on a held valid/ready output.
- Sits between the adder datapath and any result sink, such as a display or UART stage.

---
 rtl/sum_accumulator_if.sv | 23 ++
 rtl/sum_accumulator.sv | 94 +++++++++
 tb/tb_sum_accumulator.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/sum_accumulator_if.sv
// rtl/sum_accumulator_if.sv - sample input and result output handshake bundle for sum_accumulator
interface sum_accumulator_if #(
    parameter int IN_W  = 5,
    parameter int ACC_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [IN_W-1:0]  out_avg;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_avg
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_avg
    );
endinterface

// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - accumulates CNT samples per block, then holds total and average until taken
module sum_accumulator #(
    parameter int IN_W  = 5,
    parameter int CNT   = 8,
    parameter int ACC_W = IN_W + $clog2(CNT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    sum_accumulator_if.slave         bus,
    output logic [$clog2(CNT)-1:0]   sample_cnt
);
    localparam int LOG2_CNT = $clog2(CNT);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [LOG2_CNT-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0]    sum_q, sum_d;
    logic [IN_W-1:0]     avg_q, avg_d;

    logic                accept;
    logic [ACC_W-1:0]    acc_plus;

    // Handshake outputs come straight from state so no input can ripple to in_ready.
    assign bus.in_ready  = (state_q == ST_ACCUM);
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.out_sum   = sum_q;
    assign bus.out_avg   = avg_q;
    assign sample_cnt    = cnt_q;

    assign accept   = bus.in_valid && (state_q == ST_ACCUM) && !clr;
    assign acc_plus = acc_q + {{(ACC_W-IN_W){1'b0}}, bus.in_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            avg_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            avg_q   <= avg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        avg_d   = avg_q;

        if (clr) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (accept) begin
                        if (cnt_q == LOG2_CNT'(CNT - 1)) begin
                            // Dividing by a power-of-two CNT is a plain bit slice.
                            sum_d   = acc_plus;
                            avg_d   = acc_plus[LOG2_CNT +: IN_W];
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = ST_HOLD;
                        end else begin
                            acc_d = acc_plus;
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        state_d = ST_ACCUM;
                    end
                end
                default: begin
                    state_d = ST_ACCUM;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sum_accumulator.sv
// tb/tb_sum_accumulator.sv - directed self-checking bench for sum_accumulator
module tb_sum_accumulator;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic [2:0] sample_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    sum_accumulator_if #(.IN_W(5), .ACC_W(8)) bus ();

    sum_accumulator #(.IN_W(5), .CNT(8), .ACC_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .bus        (bus),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        step();
        step();
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_sum", 32'(bus.out_sum), 0);
        check("rst_out_avg", 32'(bus.out_avg), 0);
        check("rst_sample_cnt", 32'(sample_cnt), 0);
        rst_n = 1'b1;
        step();
        check("rst_in_ready", 32'(bus.in_ready), 1);

        // basic block 8 x 30
        for (int i = 0; i < 7; i++) push(5'd30);
        check("basic_pre_valid", 32'(bus.out_valid), 0);
        check("basic_pre_cnt", 32'(sample_cnt), 7);
        push(5'd30);
        check("basic_valid", 32'(bus.out_valid), 1);
        check("basic_sum", 32'(bus.out_sum), 240);
        check("basic_avg", 32'(bus.out_avg), 30);
        check("basic_hold_in_ready", 32'(bus.in_ready), 0);
        step();
        check("basic_after_valid", 32'(bus.out_valid), 0);
        check("basic_after_in_ready", 32'(bus.in_ready), 1);
        check("basic_after_cnt", 32'(sample_cnt), 0);

        // max value with gaps
        for (int i = 0; i < 7; i++) begin
            push(5'd31);
            step();
            check("gap_cnt_hold", 32'(sample_cnt), 32'(i + 1));
        end
        push(5'd31);
        check("max_valid", 32'(bus.out_valid), 1);
        check("max_sum", 32'(bus.out_sum), 248);
        check("max_avg", 32'(bus.out_avg), 31);
        step();
        check("max_after_valid", 32'(bus.out_valid), 0);

        // backpressure, 1..8
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(5'(i));
        bus.in_valid = 1'b1;
        bus.in_data  = 5'd9;
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 32'(bus.out_valid), 1);
            check("bp_sum", 32'(bus.out_sum), 36);
            check("bp_avg", 32'(bus.out_avg), 4);
            check("bp_in_ready", 32'(bus.in_ready), 0);
            check("bp_cnt", 32'(sample_cnt), 0);
            if (c < 4) step();
        end
        bus.out_ready = 1'b1;
        step();
        check("bp_release_valid", 32'(bus.out_valid), 0);
        check("bp_release_cnt", 32'(sample_cnt), 0);
        step();
        bus.in_valid = 1'b0;
        check("bp_first_accept_cnt", 32'(sample_cnt), 1);
        for (int i = 0; i < 7; i++) push(5'd0);
        check("bp_next_sum", 32'(bus.out_sum), 9);
        check("bp_next_avg", 32'(bus.out_avg), 1);
        step();

        // truncated average
        for (int i = 0; i < 7; i++) push(5'd0);
        push(5'd7);
        check("trunc1_sum", 32'(bus.out_sum), 7);
        check("trunc1_avg", 32'(bus.out_avg), 0);
        step();
        for (int i = 0; i < 7; i++) push(5'd3);
        push(5'd4);
        check("trunc2_sum", 32'(bus.out_sum), 25);
        check("trunc2_avg", 32'(bus.out_avg), 3);
        step();

        // clr mid-block
        for (int i = 0; i < 3; i++) push(5'd10);
        check("clr_pre_cnt", 32'(sample_cnt), 3);
        clr          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 5'd5;
        step();
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        check("clr_cnt", 32'(sample_cnt), 0);
        check("clr_in_ready", 32'(bus.in_ready), 1);
        for (int i = 0; i < 8; i++) push(5'd2);
        check("clr_next_valid", 32'(bus.out_valid), 1);
        check("clr_next_sum", 32'(bus.out_sum), 16);
        check("clr_next_avg", 32'(bus.out_avg), 2);
        step();

        // clr discards a held result
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(5'd1);
        check("clr_hold_valid", 32'(bus.out_valid), 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_hold_dropped", 32'(bus.out_valid), 0);
        check("clr_hold_in_ready", 32'(bus.in_ready), 1);

        // async reset while holding a result
        for (int i = 0; i < 8; i++) push(5'd6);
        check("ar_pre_valid", 32'(bus.out_valid), 1);
        check("ar_pre_sum", 32'(bus.out_sum), 48);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", 32'(bus.out_valid), 0);
        check("ar_out_sum", 32'(bus.out_sum), 0);
        check("ar_out_avg", 32'(bus.out_avg), 0);
        check("ar_cnt", 32'(sample_cnt), 0);
        step();
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        step();
        check("ar_in_ready", 32'(bus.in_ready), 1);
        for (int i = 0; i < 8; i++) push(5'd5);
        check("ar_block_valid", 32'(bus.out_valid), 1);
        check("ar_block_sum", 32'(bus.out_sum), 40);
        check("ar_block_avg", 32'(bus.out_avg), 5);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
